// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks register-file port A over [FIRST_REG, LAST_REG] and
// streams each sampled value, tagged with its index, on a valid/ready link.
module reg_dump_reader #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        Clock,
    input  logic        Reset_n,
    input  logic        Start,
    output logic [4:0]  Ra,
    input  logic [31:0] busA,
    output logic        Busy,
    output logic [31:0] Dout,
    output logic [4:0]  Dout_idx,
    output logic        Dout_valid,
    input  logic        Dout_ready,
    output logic        Done
);

    localparam int unsigned IDX_W  = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic [IDX_W-1:0]    dout_idx_q, dout_idx_d;
    logic                dout_valid_q, dout_valid_d;
    logic                done_q, done_d;

    // State and output registers; reset aborts any dump in progress.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            dout_q       <= '0;
            dout_idx_q   <= '0;
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dout_q       <= dout_d;
            dout_idx_q   <= dout_idx_d;
            dout_valid_q <= dout_valid_d;
            done_q       <= done_d;
        end
    end

    // Next-state and registered-output logic; outputs hold unless updated.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dout_d       = dout_q;
        dout_idx_d   = dout_idx_q;
        dout_valid_d = dout_valid_q;
        done_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    idx_d   = FIRST_IDX;
                    state_d = READ;
                end
            end
            READ: begin
                dout_d       = busA;
                dout_idx_d   = idx_q;
                dout_valid_d = 1'b1;
                state_d      = HOLD;
            end
            HOLD: begin
                if (dout_valid_q && Dout_ready) begin
                    dout_valid_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = READ;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Port-A address and busy flag decoded from state; address parks at 0 when idle.
    always_comb begin
        Busy = 1'b0;
        Ra   = '0;
        if (state_q == READ || state_q == HOLD) begin
            Busy = 1'b1;
            Ra   = idx_q;
        end
    end

    assign Dout       = dout_q;
    assign Dout_idx   = dout_idx_q;
    assign Dout_valid = dout_valid_q;
    assign Done       = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: a behavioural register file feeds busA,
// expected words are queued at dump start and retired on each handshake.
module tb_reg_dump_reader;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } word_t;

    logic        Clock;
    logic        Reset_n;
    logic        Start, Start1;
    logic [4:0]  Ra, Ra1;
    logic [31:0] busA, busA1;
    logic        Busy, Busy1;
    logic [31:0] Dout, Dout1;
    logic [4:0]  Dout_idx, Dout_idx1;
    logic        Dout_valid, Dout_valid1;
    logic        Dout_ready, Dout_ready1;
    logic        Done, Done1;

    logic [31:0] regs [32];
    word_t       sb [$];
    int          n_tests;
    int          n_fail;

    logic        prev_hold;
    logic [31:0] prev_dout;
    logic [4:0]  prev_idx;

    reg_dump_reader dut (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .Ra(Ra), .busA(busA),
        .Busy(Busy), .Dout(Dout), .Dout_idx(Dout_idx), .Dout_valid(Dout_valid),
        .Dout_ready(Dout_ready), .Done(Done)
    );

    reg_dump_reader #(.FIRST_REG(31), .LAST_REG(31)) dut1 (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start1), .Ra(Ra1), .busA(busA1),
        .Busy(Busy1), .Dout(Dout1), .Dout_idx(Dout_idx1), .Dout_valid(Dout_valid1),
        .Dout_ready(Dout_ready1), .Done(Done1)
    );

    // Register file read port: register 0 reads as zero.
    assign busA  = (Ra == 5'd0)  ? 32'd0 : regs[Ra];
    assign busA1 = (Ra1 == 5'd0) ? 32'd0 : regs[Ra1];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] reg_model(input int k);
        return (k == 0) ? 32'd0 : regs[k];
    endfunction

    task automatic push_dump();
        word_t w;
        for (int k = 0; k <= 31; k++) begin
            w.idx  = 5'(k);
            w.data = reg_model(k);
            sb.push_back(w);
        end
    endtask

    // Retire words on handshake, check stability under backpressure and Ra tracking.
    always @(negedge Clock) begin
        word_t e;
        if (Reset_n && Dout_valid) begin
            check_eq("ra_tracks_idx", 32'(Ra), 32'(Dout_idx));
            if (prev_hold) begin
                check_eq("bp_data_stable", Dout, prev_dout);
                check_eq("bp_idx_stable", 32'(Dout_idx), 32'(prev_idx));
            end
            if (Dout_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_depth_at_handshake", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check_eq("word_idx", 32'(Dout_idx), 32'(e.idx));
                    check_eq("word_data", Dout, e.data);
                end
            end
            prev_hold = !Dout_ready;
            prev_dout = Dout;
            prev_idx  = Dout_idx;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // One default-range dump; called at 1 time unit after a rising edge with the DUT idle.
    task automatic run_dump(input bit bp, input bit spurious);
        int cyc, busy_cnt, done_cnt, done_cyc;
        bit timed_out, injected;
        push_dump();
        Start = 1'b1;
        @(posedge Clock); #1;
        cyc = 0; busy_cnt = 0; done_cnt = 0; done_cyc = -1;
        timed_out = 1'b1; injected = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            Start = 1'b0;
            if (Busy) busy_cnt++;
            if (Done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                if (spurious) Start = 1'b1;
            end
            if (spurious && !injected && Dout_valid && Dout_idx == 5'd5) begin
                Start    = 1'b1;
                injected = 1'b1;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check_eq("idle_after_fin_busy", 32'(Busy), 32'd0);
                check_eq("idle_after_fin_done", 32'(Done), 32'd0);
            end
            if (done_cyc >= 0 && cyc == done_cyc + 4) begin
                timed_out = 1'b0;
                break;
            end
            Dout_ready = bp ? ((cyc % 3) == 2) : 1'b1;
            @(posedge Clock); #1;
            cyc++;
        end
        Start      = 1'b0;
        Dout_ready = 1'b1;
        check_eq("dump_timeout", 32'(timed_out), 32'd0);
        check_eq("done_pulses", 32'(done_cnt), 32'd1);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        check_eq("busy_after_dump", 32'(Busy), 32'd0);
        if (!bp) begin
            // Done observed after edge 2N, i.e. occupying cycle 2N+1 after accept.
            check_eq("done_latency", 32'(done_cyc), 32'd64);
            check_eq("busy_cycles", 32'(busy_cnt), 32'd64);
        end
    endtask

    initial begin
        int cyc, starts, last_done;
        bit prev_busy, timed_out;
        n_tests = 0; n_fail = 0;
        prev_hold = 1'b0; prev_dout = '0; prev_idx = '0;
        for (int k = 0; k < 32; k++) regs[k] = 32'h1000_0000 + 32'(k);
        Reset_n = 1'b0; Start = 1'b0; Start1 = 1'b0;
        Dout_ready = 1'b1; Dout_ready1 = 1'b1;

        // Reset state
        @(posedge Clock); #1;
        check_eq("rst_dout", Dout, 32'd0);
        check_eq("rst_idx", 32'(Dout_idx), 32'd0);
        check_eq("rst_valid", 32'(Dout_valid), 32'd0);
        check_eq("rst_busy", 32'(Busy), 32'd0);
        check_eq("rst_ra", 32'(Ra), 32'd0);
        check_eq("rst_done", 32'(Done), 32'd0);
        #3 Reset_n = 1'b1;
        @(posedge Clock); #1;

        // Full dump, ready high
        run_dump(1'b0, 1'b0);
        // Backpressure 0,0,1
        run_dump(1'b1, 1'b0);
        // Start at word 5 and in FIN is ignored
        run_dump(1'b0, 1'b1);

        // Reset while word 12 is presented
        push_dump();
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (Dout_valid && Dout_idx == 5'd12) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge Clock); #1;
        end
        check_eq("wait_idx12_timeout", 32'(timed_out), 32'd0);
        #2 Reset_n = 1'b0;
        #1;
        check_eq("abort_dout", Dout, 32'd0);
        check_eq("abort_idx", 32'(Dout_idx), 32'd0);
        check_eq("abort_valid", 32'(Dout_valid), 32'd0);
        check_eq("abort_busy", 32'(Busy), 32'd0);
        check_eq("abort_ra", 32'(Ra), 32'd0);
        sb.delete();
        repeat (2) begin
            @(posedge Clock); #1;
            check_eq("abort_no_done", 32'(Done), 32'd0);
        end
        #3 Reset_n = 1'b1;
        @(posedge Clock); #1;
        check_eq("post_abort_done", 32'(Done), 32'd0);
        run_dump(1'b0, 1'b0);

        // Start held high: back-to-back dumps with a single idle cycle between
        Start = 1'b1;
        starts = 0; last_done = -1; prev_busy = 1'b0;
        for (cyc = 1; cyc <= 200; cyc++) begin
            @(posedge Clock); #1;
            if (Busy && !prev_busy) begin
                starts++;
                push_dump();
                if (last_done >= 0) check_eq("held_idle_gap", 32'(cyc - last_done), 32'd2);
            end
            if (Done) last_done = cyc;
            prev_busy = Busy;
        end
        Start = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge Clock); #1;
            if (!Busy && !Dout_valid) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(posedge Clock); #1;
        check_eq("held_drain_timeout", 32'(timed_out), 32'd0);
        check_eq("held_starts", 32'(starts), 32'd4);
        check_eq("held_sb_drained", 32'(sb.size()), 32'd0);

        // Single-register range at index 31
        regs[31] = 32'hDEAD_BEEF;
        Start1 = 1'b1;
        @(posedge Clock); #1;
        Start1 = 1'b0;
        check_eq("single_read_busy", 32'(Busy1), 32'd1);
        check_eq("single_read_ra", 32'(Ra1), 32'd31);
        @(posedge Clock); #1;
        check_eq("single_valid", 32'(Dout_valid1), 32'd1);
        check_eq("single_idx", 32'(Dout_idx1), 32'd31);
        check_eq("single_data", Dout1, 32'hDEAD_BEEF);
        check_eq("single_no_early_done", 32'(Done1), 32'd0);
        @(posedge Clock); #1;
        check_eq("single_done", 32'(Done1), 32'd1);
        check_eq("single_valid_drop", 32'(Dout_valid1), 32'd0);
        check_eq("single_busy_fin", 32'(Busy1), 32'd0);
        @(posedge Clock); #1;
        check_eq("single_done_pulse", 32'(Done1), 32'd0);
        check_eq("single_idle_busy", 32'(Busy1), 32'd0);
        check_eq("single_idle_ra", 32'(Ra1), 32'd0);
        check_eq("single_idx_no_wrap", 32'(Dout_idx1), 32'd31);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Debug read-out engine for the single-cycle CPU register file. On a start pulse it walks a read address over a contiguous range of general-purpose registers, samples each value from the register file's combinational read bus, and streams the values out one per transfer on a valid/ready interface, with the register index attached. It is the consumer of the register file's read side, sitting between the register file's port-A address mux and the debug/trace link.

## Interface
Parameters:
- FIRST_REG, 0, first register index dumped (5-bit); must satisfy FIRST_REG <= LAST_REG.
- LAST_REG, 31, last register index dumped (5-bit).

Ports:
- Clock  in  1  single clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  request a dump; sampled only in IDLE.
- Ra  out  5  read address to register file port A (selected through the port-A mux while Busy=1).
- busA  in  32  combinational read data from the register file for address Ra.
- Busy  out  1  high from the cycle after Start is accepted until the final handshake completes; CPU holds register writes while high.
- Dout  out  32  sampled register value.
- Dout_idx  out  5  register index of Dout.
- Dout_valid  out  1  Dout/Dout_idx valid.
- Dout_ready  in  1  downstream accepts the current word.
- Done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States: IDLE, READ, HOLD, FIN.
- IDLE: Busy=0, Dout_valid=0, Ra=0. If Start=1 at a rising edge: idx<=FIRST_REG, go to READ.
- READ: Busy=1, Ra=idx. At the rising edge Dout<=busA, Dout_idx<=idx, Dout_valid<=1, go to HOLD. Register 0 yields 0 (register file behaviour; no special case here).
- HOLD: Busy=1, Ra=idx held stable, Dout/Dout_idx/Dout_valid held stable while Dout_ready=0 (no change allowed under backpressure).
  - Handshake = Dout_valid & Dout_ready at a rising edge.
  - On handshake with idx != LAST_REG: idx<=idx+1, Dout_valid<=0, go to READ.
  - On handshake with idx == LAST_REG: Dout_valid<=0, go to FIN.
- FIN: Busy=0, Done=1 for exactly this cycle, Start ignored, go to IDLE next edge.
- Start in READ/HOLD/FIN is ignored; no queuing. Start held high continuously re-triggers on the first IDLE edge after FIN.
- idx is 5 bits; never increments past LAST_REG, so no wrap occurs, including LAST_REG=31.
- Values are sampled in the READ cycle; consistency across the dump relies on the CPU holding writes while Busy=1.

## Timing
- Reset (Reset_n=0, asynchronous): state=IDLE, Ra=0, Busy=0, Dout=0, Dout_idx=0, Dout_valid=0, Done=0, idx=0. Reset mid-dump aborts immediately; no Done pulse; the partial word is dropped.
- Start accepted at edge E0: READ during cycle E0..E1, first Dout_valid=1 from E1.
- With Dout_ready tied high, each register takes 2 cycles (READ + HOLD); N = LAST_REG-FIRST_REG+1 words, Done asserted 2N+1 cycles after the accepting edge, first IDLE cycle at 2N+2.
- Dout_valid never deasserts without a handshake, except on reset.
- All outputs are registered except Ra and Busy, which are decoded from state/idx (glitch-free relative to Clock domain use only).

## Test plan
- Full dump, ready=1: preload Register[k]=32'h1000_0000+k (k=1..31), pulse Start -> 32 words, Dout_idx 0..31, Dout 0 then 32'h1000_0001..32'h1000_001F; Done exactly 65 cycles after the accepting edge; Busy high for 64 cycles.
- Backpressure: toggle Dout_ready 0,0,1 repeatedly -> Dout/Dout_idx stable during each ready=0 stretch, no word skipped or duplicated, Ra equals Dout_idx throughout HOLD.
- Start while busy: pulse Start at word 5 and in the FIN cycle -> sequence unchanged, single Done, returns to IDLE with no new dump.
- Reset mid-dump: assert Reset_n=0 while Dout_valid=1 at idx=12 -> all outputs 0 asynchronously, no Done; a new Start after release dumps from FIRST_REG.
- Single-register range, FIRST_REG=LAST_REG=31, Register[31]=32'hDEAD_BEEF -> one word {idx 31, 32'hDEAD_BEEF}, Done 3 cycles after accept, idx does not wrap.
- Start held high for 200 cycles with default range -> back-to-back dumps separated by exactly one IDLE cycle after each FIN.
